hex_scan_driver: RTL and testbench

HEX_SCAN_DRIVER -- requirements
Module: hex_scan_driver

---
 rtl/hex_scan_driver.sv | 121 ++++++++++++
 tb/tb_hex_scan_driver.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_driver.sv
// Time-multiplexed driver for DIGITS common-anode 7-segment digits.
// The displayed value changes only at frame boundaries, so no frame ever mixes two values.
module hex_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        load,
    input  logic [4*DIGITS-1:0]         value,
    input  logic                        blank_lz,
    output logic [3:0]                  nibble,
    output logic [DIGITS-1:0]           digit_en,
    output logic                        frame_done,
    output logic [$clog2(DIGITS)-1:0]   dbg_idx,
    output logic [$clog2(PRESCALE)-1:0] dbg_cnt,
    output logic                        dbg_pend_valid
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] shown_q, shown_d;
    logic [4*DIGITS-1:0] pend_q, pend_d;
    logic                pend_vld_q, pend_vld_d;
    logic [3:0]          nibble_q, nibble_d;
    logic [DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                frame_done_q, frame_done_d;

    logic                tick;
    logic                wrap;
    logic [DIGITS-1:0]   nz;
    logic [DIGITS-1:0]   one_hot;
    logic                blank;

    always_comb begin
        tick = enable && (cnt_q == CNT_MAX);
        wrap = tick && (idx_q == IDX_MAX);

        cnt_d = cnt_q;
        if (tick)
            cnt_d = '0;
        else if (enable)
            cnt_d = cnt_q + 1'b1;

        idx_d = idx_q;
        if (wrap)
            idx_d = '0;
        else if (tick)
            idx_d = idx_q + 1'b1;

        // A load landing on the wrap tick goes straight to shown; pending is left untouched.
        shown_d    = shown_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (wrap) begin
            pend_vld_d = 1'b0;
            if (load)
                shown_d = value;
            else if (pend_vld_q)
                shown_d = pend_q;
        end else if (load) begin
            pend_d     = value;
            pend_vld_d = 1'b1;
        end

        nibble_d = '0;
        nz       = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nz[i] = |shown_q[4*i +: 4];
            if (idx_q == IDX_W'(i))
                nibble_d = shown_q[4*i +: 4];
        end

        // Leading zero: this digit and every more-significant digit are zero.
        blank   = blank_lz && (idx_q != '0) && ((nz >> idx_q) == '0);
        one_hot = DIGITS'(1) << idx_q;

        if (!enable || blank)
            digit_en_d = '1;
        else
            digit_en_d = ~one_hot;

        frame_done_d = wrap;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shown_q      <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            nibble_q     <= '0;
            digit_en_q   <= ~DIGITS'(1);
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shown_q      <= shown_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            nibble_q     <= nibble_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign nibble         = nibble_q;
    assign digit_en       = digit_en_q;
    assign frame_done     = frame_done_q;
    assign dbg_idx        = idx_q;
    assign dbg_cnt        = cnt_q;
    assign dbg_pend_valid = pend_vld_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench for hex_scan_driver at DIGITS=4, PRESCALE=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_hex_scan_driver;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic [3:0]  nibble;
    logic [3:0]  digit_en;
    logic        frame_done;
    logic [1:0]  dbg_idx;
    logic [1:0]  dbg_cnt;
    logic        dbg_pend_valid;

    int total = 0;
    int bad   = 0;

    hex_scan_driver #(.DIGITS(4), .PRESCALE(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .load           (load),
        .value          (value),
        .blank_lz       (blank_lz),
        .nibble         (nibble),
        .digit_en       (digit_en),
        .frame_done     (frame_done),
        .dbg_idx        (dbg_idx),
        .dbg_cnt        (dbg_cnt),
        .dbg_pend_valid (dbg_pend_valid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns on the falling edge where frame_done is seen high.
    task automatic wait_fd();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!frame_done && n < 100);
        check("frame_done_timeout", frame_done, 1);
    endtask

    // Checks the 16 output cycles of one frame starting right after frame_done.
    // Optionally pulses load for one cycle after check number load_at.
    task automatic check_frame(input logic [15:0] val, input bit blank,
                               input int load_at, input logic [15:0] load_val);
        logic [3:0] one;
        logic [3:0] exp_en;
        logic [3:0] exp_nib;
        bit         blanked;
        one = 4'b0001;
        for (int s = 0; s < 4; s++) begin
            for (int r = 0; r < 4; r++) begin
                @(negedge clock);
                exp_nib = val[4*s +: 4];
                blanked = blank && (s > 0) && ((val >> (4*s)) == 16'h0);
                exp_en  = blanked ? 4'b1111 : ~(one << s);
                check($sformatf("nibble v%04h s%0d r%0d", val, s, r), nibble, exp_nib);
                check($sformatf("digit_en v%04h s%0d r%0d", val, s, r), digit_en, exp_en);
                check($sformatf("frame_done v%04h s%0d r%0d", val, s, r), frame_done,
                      (s == 3 && r == 3) ? 1 : 0);
                if (4*s + r == load_at) begin
                    load  = 1'b1;
                    value = load_val;
                end else begin
                    load  = 1'b0;
                end
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        load     = 1'b0;
        value    = 16'h0;
        blank_lz = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_nibble", nibble, 4'h0);
        check("rst_digit_en", digit_en, 4'b1110);
        check("rst_frame_done", frame_done, 0);
        check("rst_idx", dbg_idx, 0);
        check("rst_cnt", dbg_cnt, 0);
        check("rst_pend", dbg_pend_valid, 0);

        // Scan of 1234: load goes to pending, shown at first frame boundary
        reset  = 1'b0;
        enable = 1'b1;
        load   = 1'b1;
        value  = 16'h1234;
        @(negedge clock);
        load = 1'b0;
        check("pend_after_load", dbg_pend_valid, 1);
        wait_fd();
        check("pend_after_xfer", dbg_pend_valid, 0);
        check_frame(16'h1234, 0, -1, 16'h0);
        check_frame(16'h1234, 0, -1, 16'h0);

        // Load ABCD while idx=2: current frame unaffected
        check_frame(16'h1234, 0, 8, 16'hABCD);
        check_frame(16'hABCD, 0, -1, 16'h0);

        // Load on the wrap tick goes straight to shown
        check_frame(16'hABCD, 0, 14, 16'h00F0);
        check("pend_coincident", dbg_pend_valid, 0);
        check_frame(16'h00F0, 0, -1, 16'h0);
        check("pend_coincident_later", dbg_pend_valid, 0);

        // Leading-zero blanking
        check_frame(16'h00F0, 0, 0, 16'h0050);
        blank_lz = 1'b1;
        check_frame(16'h0050, 1, 0, 16'h0000);
        check_frame(16'h0000, 1, -1, 16'h0);
        blank_lz = 1'b0;

        // Enable freeze at idx=1, cnt=2; load still accepted
        repeat (6) @(negedge clock);
        check("pre_freeze_idx", dbg_idx, 1);
        check("pre_freeze_cnt", dbg_cnt, 2);
        enable = 1'b0;
        load   = 1'b1;
        value  = 16'h5A5A;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            load = 1'b0;
            check($sformatf("freeze_digit_en %0d", i), digit_en, 4'b1111);
            check($sformatf("freeze_frame_done %0d", i), frame_done, 0);
            check($sformatf("freeze_idx %0d", i), dbg_idx, 1);
            check($sformatf("freeze_cnt %0d", i), dbg_cnt, 2);
        end
        check("freeze_pend", dbg_pend_valid, 1);
        enable = 1'b1;
        @(negedge clock);
        check("resume1_idx", dbg_idx, 1);
        check("resume1_cnt", dbg_cnt, 3);
        check("resume1_digit_en", digit_en, 4'b1101);
        @(negedge clock);
        check("resume2_idx", dbg_idx, 2);
        check("resume2_cnt", dbg_cnt, 0);
        check("resume2_digit_en", digit_en, 4'b1101);
        @(negedge clock);
        check("resume3_digit_en", digit_en, 4'b1011);
        wait_fd();
        check_frame(16'h5A5A, 0, -1, 16'h0);

        // Reset mid-frame at idx=3 discards a pending load
        load  = 1'b1;
        value = 16'h7777;
        @(negedge clock);
        load = 1'b0;
        repeat (12) @(negedge clock);
        check("pre_reset_idx", dbg_idx, 3);
        check("pre_reset_pend", dbg_pend_valid, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrst_nibble", nibble, 4'h0);
        check("midrst_digit_en", digit_en, 4'b1110);
        check("midrst_frame_done", frame_done, 0);
        check("midrst_idx", dbg_idx, 0);
        check("midrst_pend", dbg_pend_valid, 0);
        wait_fd();
        check_frame(16'h0000, 0, -1, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
